// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the seven-segment display path:
//   - segment patterns for BCD 0..9, dash, all-off (active-high, bit 7 = dp)
//   - all-off digit strobe value (active-low common cathode)
//   - digit count of the shared display module
//   - helper that builds the one-hot-low strobe for a digit index
// ----------------------------------------------------------------------------
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [7:0] SEG_0    = 8'h3F;
    localparam logic [7:0] SEG_1    = 8'h06;
    localparam logic [7:0] SEG_2    = 8'h5B;
    localparam logic [7:0] SEG_3    = 8'h4F;
    localparam logic [7:0] SEG_4    = 8'h66;
    localparam logic [7:0] SEG_5    = 8'h6D;
    localparam logic [7:0] SEG_6    = 8'h7D;
    localparam logic [7:0] SEG_7    = 8'h07;
    localparam logic [7:0] SEG_8    = 8'h7F;
    localparam logic [7:0] SEG_9    = 8'h67;
    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_OFF  = 8'h00;
    localparam logic [7:0] COM_OFF  = 8'hFF;

    // Active-low strobe selecting exactly one digit.
    function automatic logic [7:0] com_strobe(input logic [2:0] idx);
        return ~(8'h01 << idx);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD nibble to seven-segment pattern (bits 6:0 = g..a,
// active-high). Non-BCD codes A..F show a dash.
// Ports:
//   nibble  in  [3:0]  BCD digit
//   seg     out [6:0]  segment pattern
// ----------------------------------------------------------------------------
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pattern lookup; anything outside 0..9 renders as a dash.
    always_comb begin
        seg = SEG_DASH[6:0];
        case (nibble)
            4'd0:    seg = SEG_0[6:0];
            4'd1:    seg = SEG_1[6:0];
            4'd2:    seg = SEG_2[6:0];
            4'd3:    seg = SEG_3[6:0];
            4'd4:    seg = SEG_4[6:0];
            4'd5:    seg = SEG_5[6:0];
            4'd6:    seg = SEG_6[6:0];
            4'd7:    seg = SEG_7[6:0];
            4'd8:    seg = SEG_8[6:0];
            4'd9:    seg = SEG_9[6:0];
            default: seg = SEG_DASH[6:0];
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// ----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexes eight BCD digits onto an 8-digit common-cathode display.
// Scans leftmost digit (7) first, CLK_DIV cycles per slot, the first
// BLANK_CYC cycles of each slot dark to avoid ghosting. Inputs are captured
// into a snapshot once per frame so a frame never mixes old and new values.
// Ports:
//   mclk        in   system clock
//   rst         in   asynchronous active-high reset
//   en          in   scan enable (0 = display dark, scan parked at digit 7)
//   digits      in   [31:0] nibble k shown on digit k
//   dp_en       in   [7:0]  decimal point per digit
//   lz_blank    in   leading-zero suppression enable
//   seg_com     out  [7:0]  digit strobes, active-low
//   seg_data    out  [7:0]  segments, active-high, bit 7 = dp
//   frame_done  out  one-cycle pulse at the end of each complete frame
// ----------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_DIV   = 10000,
    parameter int BLANK_CYC = 4
) (
    input  logic                    mclk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    input  logic                    lz_blank,
    output logic [7:0]              seg_com,
    output logic [7:0]              seg_data,
    output logic                    frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_ZERO  = PW'(1'b0);
    localparam logic [PW-1:0] P_ONE   = PW'(1'b1);
    localparam logic [PW:0]   BLANK_W = (PW + 1)'(BLANK_CYC);

    logic [2:0]              idx_r;
    logic [PW-1:0]           p_r;
    logic [4*NUM_DIGITS-1:0] snap_digits_r;
    logic [NUM_DIGITS-1:0]   snap_dp_r;
    logic                    snap_lz_r;

    logic                    term_s;
    logic                    wrap_s;
    logic                    snap_load_s;
    logic [3:0]              nibble_s;
    logic [6:0]              pat_s;
    logic [NUM_DIGITS-1:0]   zero_above_s;
    logic                    suppress_s;
    logic [7:0]              com_nxt_s;
    logic [7:0]              data_nxt_s;
    logic                    fd_nxt_s;

    assign term_s      = (p_r == P_LAST);
    assign wrap_s      = en & term_s & (idx_r == 3'd0);
    assign snap_load_s = ~en | wrap_s;
    assign nibble_s    = snap_digits_r[{idx_r, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble (nibble_s),
        .seg    (pat_s)
    );

    // zero_above_s[k]: nibble k and every higher nibble are zero.
    always_comb begin
        logic run_v;
        run_v        = 1'b1;
        zero_above_s = {NUM_DIGITS{1'b0}};
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run_v           = run_v & (snap_digits_r[4*k +: 4] == 4'h0);
            zero_above_s[k] = run_v;
        end
    end

    // Digit 0 always shows, so a zero value still displays "0".
    assign suppress_s = snap_lz_r & zero_above_s[idx_r] & (idx_r != 3'd0);

    // Next output values from the current slot state.
    always_comb begin
        com_nxt_s  = COM_OFF;
        data_nxt_s = SEG_OFF;
        fd_nxt_s   = wrap_s;
        if (!en) begin
            com_nxt_s  = COM_OFF;
            data_nxt_s = SEG_OFF;
        end else if ({1'b0, p_r} < BLANK_W) begin
            com_nxt_s  = COM_OFF;
            data_nxt_s = SEG_OFF;
        end else begin
            com_nxt_s  = com_strobe(idx_r);
            // Suppressed digits keep their strobe and dp, only segments go dark.
            data_nxt_s = {snap_dp_r[idx_r], suppress_s ? 7'h00 : pat_s};
        end
    end

    // Prescaler and slot index; en low parks the scan at the frame start.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            idx_r <= 3'd7;
            p_r   <= P_ZERO;
        end else if (!en) begin
            idx_r <= 3'd7;
            p_r   <= P_ZERO;
        end else if (term_s) begin
            idx_r <= idx_r - 3'd1;  // 0 wraps to 7
            p_r   <= P_ZERO;
        end else begin
            p_r   <= p_r + P_ONE;
        end
    end

    // Frame-coherent snapshot of the display inputs.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            snap_digits_r <= {(4*NUM_DIGITS){1'b0}};
            snap_dp_r     <= {NUM_DIGITS{1'b0}};
            snap_lz_r     <= 1'b0;
        end else if (snap_load_s) begin
            snap_digits_r <= digits;
            snap_dp_r     <= dp_en;
            snap_lz_r     <= lz_blank;
        end
    end

    // Registered outputs.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            seg_com    <= COM_OFF;
            seg_data   <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            seg_com    <= com_nxt_s;
            seg_data   <= data_nxt_s;
            frame_done <= fd_nxt_s;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_driver
// Directed bench for seg_scan_driver with CLK_DIV=4, BLANK_CYC=1.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// ----------------------------------------------------------------------------
module tb_seg_scan_driver;

    logic        mclk;
    logic        rst;
    logic        en;
    logic [31:0] digits;
    logic [7:0]  dp_en;
    logic        lz_blank;
    logic [7:0]  seg_com;
    logic [7:0]  seg_data;
    logic        frame_done;

    int n_cmp;
    int n_err;

    seg_scan_driver #(
        .CLK_DIV   (4),
        .BLANK_CYC (1)
    ) dut (
        .mclk       (mclk),
        .rst        (rst),
        .en         (en),
        .digits     (digits),
        .dp_en      (dp_en),
        .lz_blank   (lz_blank),
        .seg_com    (seg_com),
        .seg_data   (seg_data),
        .frame_done (frame_done)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [7:0] ecom,
                       input logic [7:0] edata, input logic efd);
        n_cmp++;
        assert ({seg_com, seg_data, frame_done} === {ecom, edata, efd})
        else begin
            n_err++;
            $error("FAIL %s: got com=%h data=%h fd=%b, expected com=%h data=%h fd=%b",
                   tag, seg_com, seg_data, frame_done, ecom, edata, efd);
        end
    endtask

    // One slot: one blank sample then three active samples.
    task automatic slot(input string tag, input int k, input logic [7:0] edata);
        logic [7:0] one;
        logic [7:0] ecom;
        one  = 8'h01;
        ecom = ~(one << k);
        @(negedge mclk);
        chk($sformatf("%s_d%0d_blank", tag, k), 8'hFF, 8'h00, 1'b0);
        for (int i = 1; i < 4; i++) begin
            @(negedge mclk);
            chk($sformatf("%s_d%0d_act%0d", tag, k, i), ecom, edata,
                (i == 3 && k == 0) ? 1'b1 : 1'b0);
        end
    endtask

    // Slots hi down to lo; byte k of pat is the expected seg_data of digit k.
    task automatic frame(input string tag, input logic [63:0] pat,
                         input int hi, input int lo);
        for (int k = hi; k >= lo; k--) begin
            slot(tag, k, pat[8*k +: 8]);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        en       = 1'b0;
        digits   = 32'h12345678;
        dp_en    = 8'h00;
        lz_blank = 1'b0;

        repeat (2) @(negedge mclk);
        chk("reset", 8'hFF, 8'h00, 1'b0);
        rst = 1'b0;
        @(negedge mclk);
        chk("en_low_idle", 8'hFF, 8'h00, 1'b0);
        en = 1'b1;

        // Scan order and frame_done timing over two frames.
        frame("f1", 64'h06_5B_4F_66_6D_7D_07_7F, 7, 0);
        digits = 32'h00000105; lz_blank = 1'b1;
        frame("f2", 64'h06_5B_4F_66_6D_7D_07_7F, 7, 0);

        // Leading-zero suppression.
        digits = 32'h00000000;
        frame("lz105", 64'h00_00_00_00_00_06_3F_6D, 7, 0);
        digits = 32'h11111111; lz_blank = 1'b0;
        frame("lz0", 64'h00_00_00_00_00_00_00_3F, 7, 0);

        // Tearing: new value arrives during slot 4.
        frame("tear_a", 64'h06_06_06_06_06_06_06_06, 7, 5);
        digits = 32'h22222222;
        frame("tear_b", 64'h06_06_06_06_06_06_06_06, 4, 0);
        digits = 32'h0000A000; dp_en = 8'h08; lz_blank = 1'b1;
        frame("tear_next", 64'h5B_5B_5B_5B_5B_5B_5B_5B, 7, 0);

        // Dash with dp; then dp on a suppressed digit.
        digits = 32'h00000000; dp_en = 8'h80;
        frame("dash_dp", 64'h00_00_00_00_C0_3F_3F_3F, 7, 0);
        frame("dp_supp", 64'h80_00_00_00_00_00_00_3F, 7, 0);

        // Drop en in the middle of slot 7.
        @(negedge mclk);
        chk("pre_en_blank", 8'hFF, 8'h00, 1'b0);
        @(negedge mclk);
        chk("pre_en_act", 8'h7F, 8'h80, 1'b0);
        en = 1'b0;
        digits = 32'h12345678; dp_en = 8'h00; lz_blank = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge mclk);
            chk($sformatf("en_off_%0d", i), 8'hFF, 8'h00, 1'b0);
        end
        en = 1'b1;
        slot("en_back", 7, 8'h06);
        slot("en_back", 6, 8'h5B);

        // Asynchronous reset between clock edges.
        @(negedge mclk);
        chk("pre_rst_blank", 8'hFF, 8'h00, 1'b0);
        @(negedge mclk);
        chk("pre_rst_act", 8'hDF, 8'h4F, 1'b0);
        rst = 1'b1;
        #1;
        chk("async_rst", 8'hFF, 8'h00, 1'b0);
        @(negedge mclk);
        chk("rst_held", 8'hFF, 8'h00, 1'b0);
        rst = 1'b0;
        // Snapshot was cleared by reset, so zeros show until the frame wraps.
        slot("post_rst", 7, 8'h3F);
        slot("post_rst", 6, 8'h3F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
